cap_sense_scheduler: RTL and testbench

- Time-multiplexes one charge/discharge measurement sequence across NUM_PADS capacitive pads of the whack-a-mole board.
- Per pad, in round-robin order: charges the pad, releases it, counts discharge cycles and latches the count.
- Classifies each count against a threshold and debounces the result into a per-pad hit flag.
- Sits between the pad GPIOs and the game logic, which consumes pad_hit, sample_valid and scan_done.

---
 rtl/cap_sense_scheduler.sv | 259 +++++++++++++++++++++++++
 tb/tb_cap_sense_scheduler.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cap_sense_scheduler.sv
// -----------------------------------------------------------------------------
// cap_sense_scheduler
//
// Scans NUM_PADS capacitive pads one at a time using a single charge/discharge
// measurement sequence. For each pad in round-robin order the block:
//   1. drives the pad high for CHARGE_CYCLES clocks (CHARGE),
//   2. releases it and counts cycles while the synchronized input stays high
//      (MEASURE), aborting at TIMEOUT,
//   3. presents the count for one cycle and updates that pad's debounced hit
//      flag (LATCH).
//
// Ports:
//   clock          - system clock, all state changes on its rising edge
//   reset_n        - asynchronous active-low reset
//   enable         - scanning permitted (looked at only in IDLE and LATCH)
//   threshold      - count at or above which a sample counts as a touch
//   sensor_in      - raw, asynchronous pad inputs
//   charge_out     - one-hot charge drive for the selected pad during CHARGE
//   pad_hit        - debounced per-pad touch flags
//   sample_valid   - one-cycle pulse, sample_pad/sample_count are valid
//   sample_pad     - index of the pad the sample belongs to
//   sample_count   - discharge count of the sample
//   sample_timeout - sample_valid qualifier: measurement reached TIMEOUT
//   scan_done      - one-cycle pulse alongside the last pad's sample
//   busy           - high whenever the scheduler is not IDLE
// -----------------------------------------------------------------------------
module cap_sense_scheduler #(
    parameter int NUM_PADS      = 4,
    parameter int PAD_W         = 2,
    parameter int COUNT_W       = 16,
    parameter int CHARGE_CYCLES = 500,
    parameter int TIMEOUT       = 50000,
    parameter int CONFIRM       = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [COUNT_W-1:0]  threshold,
    input  logic [NUM_PADS-1:0] sensor_in,
    output logic [NUM_PADS-1:0] charge_out,
    output logic [NUM_PADS-1:0] pad_hit,
    output logic                sample_valid,
    output logic [PAD_W-1:0]    sample_pad,
    output logic [COUNT_W-1:0]  sample_count,
    output logic                sample_timeout,
    output logic                scan_done,
    output logic                busy
);

    // -------------------------------------------------------------------------
    // Derived constants
    // -------------------------------------------------------------------------
    localparam int TIMER_W  = (CHARGE_CYCLES > 1) ? $clog2(CHARGE_CYCLES) : 1;
    localparam int STREAK_W = $clog2(CONFIRM + 1);

    localparam logic [PAD_W-1:0]    LAST_PAD    = PAD_W'(NUM_PADS - 1);
    localparam logic [TIMER_W-1:0]  CHARGE_LAST = TIMER_W'(CHARGE_CYCLES - 1);
    localparam logic [COUNT_W-1:0]  COUNT_LAST  = COUNT_W'(TIMEOUT - 1);
    localparam logic [COUNT_W-1:0]  COUNT_MAX   = COUNT_W'(TIMEOUT);
    localparam logic [STREAK_W-1:0] STREAK_MAX  = STREAK_W'(CONFIRM);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CHARGE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_LATCH   = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t                state_q,   state_d;
    logic [PAD_W-1:0]      idx_q,     idx_d;
    logic [TIMER_W-1:0]    timer_q,   timer_d;
    logic [COUNT_W-1:0]    count_q,   count_d;
    logic                  timeout_q, timeout_d;
    logic [NUM_PADS-1:0]   charge_q,  charge_d;

    // Two-flop synchronizer for every pad input.
    logic [NUM_PADS-1:0]   meta_q;
    logic [NUM_PADS-1:0]   sync_q;

    // Per-pad helper vectors built in the generate loop below.
    logic [NUM_PADS-1:0]   charge_sel;
    logic [NUM_PADS-1:0]   sync_sel;

    logic                  sync_cur;     // synchronized input of pad idx
    logic                  in_latch;
    logic                  hit_update;   // LATCH with a non-zero count
    logic                  count_above;

    // -------------------------------------------------------------------------
    // Input synchronizer
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= sensor_in;
            sync_q <= meta_q;
        end
    end

    // Pick the synchronized bit of the current pad with an AND-OR mux so the
    // index width never has to match the vector width exactly.
    assign sync_cur = |sync_sel;

    // -------------------------------------------------------------------------
    // Sequencer: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        timer_d   = timer_q;
        count_d   = count_q;
        timeout_d = timeout_q;

        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_CHARGE;
                    idx_d   = '0;
                    timer_d = '0;
                end
            end

            ST_CHARGE: begin
                timer_d = timer_q + TIMER_W'(1);
                if (timer_q == CHARGE_LAST) begin
                    state_d   = ST_MEASURE;
                    timer_d   = '0;
                    count_d   = '0;
                    timeout_d = 1'b0;
                end
            end

            ST_MEASURE: begin
                if (sync_cur) begin
                    count_d = count_q + COUNT_W'(1);
                    // Abort on the increment that would reach TIMEOUT, so the
                    // counter tops out at TIMEOUT and can never wrap.
                    if (count_q == COUNT_LAST) begin
                        count_d   = COUNT_MAX;
                        timeout_d = 1'b1;
                        state_d   = ST_LATCH;
                    end
                end else begin
                    timeout_d = 1'b0;
                    state_d   = ST_LATCH;
                end
            end

            ST_LATCH: begin
                idx_d   = (idx_q == LAST_PAD) ? '0 : idx_q + PAD_W'(1);
                timer_d = '0;
                state_d = enable ? ST_CHARGE : ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // charge_out is registered from the next state so the pad drive rises on
    // the edge that enters CHARGE and falls on the edge that enters MEASURE,
    // with no combinational decode on the GPIO path.
    assign charge_d = charge_sel;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            timer_q   <= '0;
            count_q   <= '0;
            timeout_q <= 1'b0;
            charge_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            count_q   <= count_d;
            timeout_q <= timeout_d;
            charge_q  <= charge_d;
        end
    end

    // -------------------------------------------------------------------------
    // Classification shared by all pads
    // -------------------------------------------------------------------------
    assign in_latch    = (state_q == ST_LATCH);
    // A zero count means the pad never charged (e.g. an open input); such a
    // sample carries no information and leaves the debounce state alone.
    assign hit_update  = in_latch && (count_q != '0);
    assign count_above = (count_q >= threshold);

    // -------------------------------------------------------------------------
    // Per-pad charge decode, input select and hit debounce
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PADS; gi++) begin : g_pad
            logic                pad_sel;
            logic [STREAK_W-1:0] streak_q, streak_d;
            logic                hit_q,    hit_d;

            assign pad_sel        = (idx_q == PAD_W'(gi));
            assign charge_sel[gi] = (state_d == ST_CHARGE) && (idx_d == PAD_W'(gi));
            assign sync_sel[gi]   = pad_sel && sync_q[gi];

            always_comb begin
                streak_d = streak_q;
                hit_d    = hit_q;
                if (hit_update && pad_sel) begin
                    if (timeout_q) begin
                        // A stuck-high pad is treated as a fault, not a touch.
                        streak_d = '0;
                        hit_d    = 1'b0;
                    end else if (count_above) begin
                        if (streak_q != STREAK_MAX) begin
                            streak_d = streak_q + STREAK_W'(1);
                        end
                        if (streak_d == STREAK_MAX) begin
                            hit_d = 1'b1;
                        end
                    end else begin
                        streak_d = '0;
                        hit_d    = 1'b0;
                    end
                end
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    streak_q <= '0;
                    hit_q    <= 1'b0;
                end else begin
                    streak_q <= streak_d;
                    hit_q    <= hit_d;
                end
            end

            assign pad_hit[gi] = hit_q;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign charge_out     = charge_q;
    assign sample_valid   = in_latch;
    assign sample_pad     = idx_q;
    assign sample_count   = count_q;
    assign sample_timeout = in_latch && timeout_q;
    assign scan_done      = in_latch && (idx_q == LAST_PAD);
    assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cap_sense_scheduler.sv
// -----------------------------------------------------------------------------
// tb_cap_sense_scheduler
//
// Bench for cap_sense_scheduler with NUM_PADS=4, CHARGE_CYCLES=4, TIMEOUT=100,
// CONFIRM=2 and threshold=20. A pad model keeps sensor_in high while the pad
// is charged and for D cycles after charge_out falls (or forces it stuck high
// or low). Expected samples are pushed into a queue as each scan's pad
// settings are applied and popped by a monitor on every sample_valid. A table
// of back-to-back scans carries the expected pad_hit after each scan; reset
// and enable corner cases follow as hand-written sequences.
// -----------------------------------------------------------------------------
module tb_cap_sense_scheduler;

    localparam int NP      = 4;
    localparam int PW      = 2;
    localparam int CW      = 16;
    localparam int CHG     = 4;
    localparam int TMO     = 100;
    localparam int CONF    = 2;
    localparam int NROWS   = 14;

    logic          clk;
    logic          reset_n;
    logic          enable;
    logic [CW-1:0] threshold;
    logic [NP-1:0] sensor_in;
    logic [NP-1:0] charge_out;
    logic [NP-1:0] pad_hit;
    logic          sample_valid;
    logic [PW-1:0] sample_pad;
    logic [CW-1:0] sample_count;
    logic          sample_timeout;
    logic          scan_done;
    logic          busy;

    cap_sense_scheduler #(
        .NUM_PADS      (NP),
        .PAD_W         (PW),
        .COUNT_W       (CW),
        .CHARGE_CYCLES (CHG),
        .TIMEOUT       (TMO),
        .CONFIRM       (CONF)
    ) dut (
        .clock          (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .threshold      (threshold),
        .sensor_in      (sensor_in),
        .charge_out     (charge_out),
        .pad_hit        (pad_hit),
        .sample_valid   (sample_valid),
        .sample_pad     (sample_pad),
        .sample_count   (sample_count),
        .sample_timeout (sample_timeout),
        .scan_done      (scan_done),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Bookkeeping
    // -------------------------------------------------------------------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at %0t",
                     name, act, act, req, req, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Pad model
    // -------------------------------------------------------------------------
    int       pad_d [NP];
    logic [NP-1:0] pad_hi;
    logic [NP-1:0] pad_lo;
    int       rem [NP];

    initial begin
        sensor_in = '0;
        for (int p = 0; p < NP; p++) rem[p] = 0;
    end

    always @(posedge clk) begin
        #1;
        for (int p = 0; p < NP; p++) begin
            logic s;
            if (charge_out[p]) begin
                rem[p] = pad_d[p];
                s = 1'b1;
            end else if (rem[p] > 0) begin
                rem[p] = rem[p] - 1;
                s = 1'b1;
            end else begin
                s = 1'b0;
            end
            sensor_in[p] = pad_hi[p] | (~pad_lo[p] & s);
        end
    end

    // -------------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------------
    typedef struct {
        logic [PW-1:0] pad;
        logic [CW-1:0] count;
        logic          tmo;
        logic          done;
    } exp_t;

    exp_t sb [$];

    // Expected sample for one pad, from the discharge model: the count is the
    // high time after charge release plus two synchronizer cycles, capped at
    // TIMEOUT (which also flags the sample).
    function automatic void push_exp(input int p);
        exp_t e;
        int   c;
        e.pad  = PW'(p);
        e.done = (p == NP - 1);
        if (pad_lo[p]) begin
            c     = 0;
            e.tmo = 1'b0;
        end else if (pad_hi[p]) begin
            c     = TMO;
            e.tmo = 1'b1;
        end else begin
            c     = pad_d[p] + 2;
            e.tmo = (c >= TMO);
            if (c > TMO) c = TMO;
        end
        e.count = CW'(c);
        sb.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            check("valid_during_reset", {31'd0, sample_valid}, 0);
        end else begin
            if (scan_done) begin
                check("scan_done_with_valid", {31'd0, sample_valid}, 1);
            end
            if (sample_valid) begin
                check("sample_expected", (sb.size() != 0) ? 1 : 0, 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    $display("sample pad=%0d count=%0d timeout=%0d scan_done=%0d pad_hit=%b",
                             sample_pad, sample_count, sample_timeout, scan_done, pad_hit);
                    check("sample_pad",     {30'd0, sample_pad},     {30'd0, e.pad});
                    check("sample_count",   {16'd0, sample_count},   {16'd0, e.count});
                    check("sample_timeout", {31'd0, sample_timeout}, {31'd0, e.tmo});
                    check("scan_done",      {31'd0, scan_done},      {31'd0, e.done});
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Scan table: pad settings for one full scan and pad_hit expected after it
    // -------------------------------------------------------------------------
    typedef struct packed {
        logic [7:0] d3;
        logic [7:0] d2;
        logic [7:0] d1;
        logic [7:0] d0;
        logic [3:0] hi;
        logic [3:0] lo;
        logic [3:0] hit;
    } row_t;

    row_t rows [NROWS];

    task automatic apply_row(input int r);
        pad_d[0] = int'(rows[r].d0);
        pad_d[1] = int'(rows[r].d1);
        pad_d[2] = int'(rows[r].d2);
        pad_d[3] = int'(rows[r].d3);
        pad_hi   = rows[r].hi;
        pad_lo   = rows[r].lo;
        for (int p = 0; p < NP; p++) push_exp(p);
    endtask

    // Bounded waits; all sample just after the falling edge.
    task automatic wait_scan_done(input string name);
        bit got = 1'b0;
        for (int n = 0; n < 1500 && !got; n++) begin
            @(negedge clk); #1;
            got = scan_done;
        end
        check(name, {31'd0, got}, 1);
    endtask

    task automatic wait_charge(input string name, input logic [NP-1:0] val, input bit any_nonzero);
        bit got = 1'b0;
        for (int n = 0; n < 1500 && !got; n++) begin
            @(negedge clk); #1;
            got = any_nonzero ? (charge_out != '0) : (charge_out == val);
        end
        check(name, {31'd0, got}, 1);
    endtask

    task automatic wait_sb_empty(input string name);
        bit got = 1'b0;
        for (int n = 0; n < 1500 && !got; n++) begin
            @(negedge clk); #1;
            got = (sb.size() == 0);
        end
        check(name, {31'd0, got}, 1);
    endtask

    // -------------------------------------------------------------------------
    // Main sequence
    // -------------------------------------------------------------------------
    initial begin
        //          d3     d2     d1     d0     hi       lo       hit
        rows[0]  = '{8'd10, 8'd10, 8'd10, 8'd10, 4'b0000, 4'b0000, 4'b0000};
        rows[1]  = '{8'd10, 8'd30, 8'd10, 8'd10, 4'b0000, 4'b0000, 4'b0000};
        rows[2]  = '{8'd10, 8'd30, 8'd10, 8'd10, 4'b0000, 4'b0000, 4'b0100};
        rows[3]  = '{8'd10, 8'd5,  8'd10, 8'd10, 4'b0000, 4'b0000, 4'b0000};
        rows[4]  = '{8'd10, 8'd10, 8'd10, 8'd10, 4'b0010, 4'b0000, 4'b0000};
        rows[5]  = '{8'd10, 8'd10, 8'd10, 8'd30, 4'b0000, 4'b0000, 4'b0000};
        rows[6]  = '{8'd10, 8'd10, 8'd10, 8'd30, 4'b0000, 4'b0000, 4'b0001};
        rows[7]  = '{8'd10, 8'd10, 8'd10, 8'd10, 4'b0000, 4'b0001, 4'b0001};
        rows[8]  = '{8'd10, 8'd10, 8'd10, 8'd98, 4'b0000, 4'b0000, 4'b0000};
        rows[9]  = '{8'd97, 8'd10, 8'd10, 8'd10, 4'b0000, 4'b0000, 4'b0000};
        rows[10] = '{8'd18, 8'd10, 8'd10, 8'd10, 4'b0000, 4'b0000, 4'b1000};
        rows[11] = '{8'd17, 8'd10, 8'd10, 8'd10, 4'b0000, 4'b0000, 4'b0000};
        rows[12] = '{8'd10, 8'd10, 8'd30, 8'd10, 4'b0000, 4'b0000, 4'b0000};
        rows[13] = '{8'd10, 8'd10, 8'd30, 8'd10, 4'b0000, 4'b0000, 4'b0010};

        for (int p = 0; p < NP; p++) pad_d[p] = 10;
        pad_hi    = '0;
        pad_lo    = '0;
        enable    = 1'b0;
        threshold = CW'(20);
        reset_n   = 1'b1;
        #1 reset_n = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check("rst_charge_out",     {28'd0, charge_out}, 0);
        check("rst_pad_hit",        {28'd0, pad_hit}, 0);
        check("rst_busy",           {31'd0, busy}, 0);
        check("rst_sample_valid",   {31'd0, sample_valid}, 0);
        check("rst_scan_done",      {31'd0, scan_done}, 0);
        check("rst_sample_count",   {16'd0, sample_count}, 0);
        check("rst_sample_pad",     {30'd0, sample_pad}, 0);
        check("rst_sample_timeout", {31'd0, sample_timeout}, 0);
        reset_n = 1'b1;
        @(negedge clk); #1;
        check("idle_without_enable", {31'd0, busy}, 0);

        // Back-to-back scans from the table.
        for (int r = 0; r < NROWS; r++) begin
            apply_row(r);
            if (r == 0) begin
                enable = 1'b1;
            end else begin
                @(negedge clk); #1;
                check($sformatf("pad_hit_after_scan%0d", r - 1),
                      {28'd0, pad_hit}, {28'd0, rows[r-1].hit});
            end
            wait_scan_done($sformatf("scan%0d_done_seen", r));
        end
        enable = 1'b0;
        @(negedge clk); #1;
        check($sformatf("pad_hit_after_scan%0d", NROWS - 1),
              {28'd0, pad_hit}, {28'd0, rows[NROWS-1].hit});
        check("idle_after_table", {31'd0, busy}, 0);

        // Reset during MEASURE of pad 2: everything drops at once, no sample.
        enable = 1'b1;
        push_exp(0);
        push_exp(1);
        wait_charge("charge_pad2", 4'b0100, 1'b0);
        wait_charge("measure_pad2", 4'b0000, 1'b0);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_charge_out", {28'd0, charge_out}, 0);
        check("mid_rst_pad_hit",    {28'd0, pad_hit}, 0);
        check("mid_rst_busy",       {31'd0, busy}, 0);
        check("mid_rst_sb_drained", sb.size(), 0);
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;
        push_exp(0);
        wait_charge("restart_charge", 4'b0000, 1'b1);
        check("restart_at_pad0", {28'd0, charge_out}, 4'b0001);
        wait_sb_empty("restart_pad0_sample");

        // Drop enable during CHARGE of pad 1: pad 1 still completes, then IDLE.
        wait_charge("charge_pad1", 4'b0010, 1'b0);
        enable = 1'b0;
        push_exp(1);
        wait_sb_empty("pad1_sample_after_disable");
        @(negedge clk); #1;
        check("idle_after_disable", {31'd0, busy}, 0);
        check("streak_cleared_by_reset", {28'd0, pad_hit}, 0);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk); #1;
            check("no_scan_done_when_idle", {31'd0, scan_done}, 0);
        end
        check("idle_charge_out", {28'd0, charge_out}, 0);

        // Re-enable starts again at pad 0.
        enable = 1'b1;
        push_exp(0);
        wait_charge("reenable_charge", 4'b0000, 1'b1);
        check("reenable_at_pad0", {28'd0, charge_out}, 4'b0001);
        wait_sb_empty("reenable_pad0_sample");
        enable = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("final_idle", {31'd0, busy}, 0);
        check("final_sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
